// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: per-channel TMDS receive decoder with word alignment.
// Hunts for control tokens by pulsing bitslip, then decodes video and control.
// Ports:
//   clk_pixel   in   pixel clock, rising edge
//   rst_n       in   async active-low reset
//   tmds_word   in   10-bit deserialized word, bit 0 first on the wire
//   bitslip     out  1-cycle request to shift the deserializer by one bit
//   locked      out  alignment achieved, decoded outputs valid
//   de          out  1 = video byte on data_out, 0 = control period
//   data_out    out  decoded video byte
//   ctrl        out  {c1,c0} of the last control token
//   slip_count  out  bitslips since last lock attempt, wraps 9->0
`timescale 1ns/1ps
module tmds_channel_decoder #(
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [7:0] data_out,
  output logic [1:0] ctrl,
  output logic [3:0] slip_count
);

  localparam int MAXW = (SEARCH_WINDOW > LOSS_WINDOW) ?
                        SEARCH_WINDOW : LOSS_WINDOW;
  localparam int CW   = $clog2(MAXW);
  localparam int RW   = $clog2(LOCK_COUNT + 1);
  localparam int SCW  = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;

  localparam logic [CW-1:0]  SW_LAST  = CW'(SEARCH_WINDOW - 1);
  localparam logic [CW-1:0]  LW_LAST  = CW'(LOSS_WINDOW - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [RW-1:0]  RUN_LAST = RW'(LOCK_COUNT - 1);
  localparam logic [RW-1:0]  RUN_ONE  = RW'(1);
  localparam logic [SCW-1:0] SET_LAST = SCW'(SLIP_SETTLE - 1);
  localparam logic [SCW-1:0] SET_ONE  = SCW'(1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_win;
  logic [CW-1:0]  r_wd;
  logic [RW-1:0]  r_run;
  logic [SCW-1:0] r_settle;
  logic [3:0]     r_slip_cnt;
  logic           r_bitslip;

  logic [9:0]     r_s1_word;
  logic           r_s1_tok;
  logic [1:0]     r_s1_ctl;

  logic           r_locked;
  logic           r_de;
  logic [7:0]     r_data;
  logic [1:0]     r_ctrl;

  logic           w_tok;
  logic [1:0]     w_tok_val;
  logic [7:0]     w_q;
  logic [7:0]     w_dec;
  logic           w_go_lock;
  logic           w_drop;
  logic           w_lock_nxt;

  // Control token recognition on the raw input word.
  always_comb begin
    w_tok     = 1'b1;
    w_tok_val = 2'b00;
    unique case (tmds_word)
      10'b1101010100: w_tok_val = 2'b00;
      10'b0010101011: w_tok_val = 2'b01;
      10'b0101010100: w_tok_val = 2'b10;
      10'b1010101011: w_tok_val = 2'b11;
      default:        w_tok     = 1'b0;
    endcase
  end

  // Stage 1: word plus token flag/value.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_word <= '0;
      r_s1_tok  <= 1'b0;
      r_s1_ctl  <= 2'b00;
    end else begin
      r_s1_word <= tmds_word;
      r_s1_tok  <= w_tok;
      r_s1_ctl  <= w_tok_val;
    end
  end

  // TMDS video decode: undo the optional inversion, then the XOR/XNOR chain.
  assign w_q = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];

  always_comb begin
    w_dec    = '0;
    w_dec[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = r_s1_word[8] ? (w_q[i] ^ w_q[i-1])
                              : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  // Lock transitions, shared with stage 2 so outputs switch with locked.
  assign w_go_lock  = (r_state == ST_VERIFY) && r_s1_tok &&
                      (r_run == RUN_LAST);
  assign w_drop     = (r_state == ST_LOCKED) && !r_s1_tok &&
                      (r_wd == LW_LAST);
  assign w_lock_nxt = w_go_lock || (r_locked && !w_drop);

  // Alignment FSM, acting on the stage-1 token flag.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEARCH;
      r_win      <= '0;
      r_wd       <= '0;
      r_run      <= '0;
      r_settle   <= '0;
      r_slip_cnt <= 4'd0;
      r_bitslip  <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (r_s1_tok) begin
            r_win   <= '0;
            r_run   <= RUN_ONE;
            r_state <= ST_VERIFY;
          end else if (r_win == SW_LAST) begin
            r_bitslip  <= 1'b1;
            r_slip_cnt <= (r_slip_cnt == 4'd9) ? 4'd0
                                               : r_slip_cnt + 4'd1;
            r_settle   <= '0;
            r_win      <= '0;
            r_state    <= ST_SLIP_WAIT;
          end else begin
            r_win <= r_win + CNT_ONE;
          end
        end
        ST_SLIP_WAIT: begin
          if (r_settle == SET_LAST) begin
            r_win   <= '0;
            r_state <= ST_SEARCH;
          end else begin
            r_settle <= r_settle + SET_ONE;
          end
        end
        ST_VERIFY: begin
          if (r_s1_tok) begin
            r_run <= r_run + RUN_ONE;
            if (r_run == RUN_LAST) begin
              r_wd       <= '0;
              r_slip_cnt <= 4'd0;
              r_state    <= ST_LOCKED;
            end
          end else begin
            // Broken token run: restart the hunt without slipping.
            r_run   <= '0;
            r_win   <= '0;
            r_state <= ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (r_s1_tok) begin
            r_wd <= '0;
          end else if (r_wd == LW_LAST) begin
            r_win   <= '0;
            r_run   <= '0;
            r_state <= ST_SEARCH;
          end else begin
            r_wd <= r_wd + CNT_ONE;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  // Stage 2: decoded outputs, forced quiet whenever not locked.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_de     <= 1'b0;
      r_data   <= 8'h00;
      r_ctrl   <= 2'b00;
    end else begin
      r_locked <= w_lock_nxt;
      if (!w_lock_nxt) begin
        r_de   <= 1'b0;
        r_data <= 8'h00;
        r_ctrl <= 2'b00;
      end else if (r_s1_tok) begin
        r_de   <= 1'b0;
        r_data <= 8'h00;
        r_ctrl <= r_s1_ctl;
      end else begin
        r_de   <= 1'b1;
        r_data <= w_dec;
      end
    end
  end

  assign bitslip    = r_bitslip;
  assign locked     = r_locked;
  assign de         = r_de;
  assign data_out   = r_data;
  assign ctrl       = r_ctrl;
  assign slip_count = r_slip_cnt;

endmodule
